// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_buffer_pkg;

   // Canonical nop (addi x0, x0, 0); replaces the word of a faulted fetch
   localparam logic [31:0] nop_instr        = 32'h0000_0013;
   localparam logic [31:0] reset_pc_default = 32'h0000_0000;

   // One queued fetch result
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        error;
   } fetch_entry_type;

   // Decode-side bundle
   typedef struct packed {
      logic ready;
   } fetch_in_type;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        error;
   } fetch_out_type;

   // Instruction memory request/response
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } imem_req_type;

   typedef struct packed {
      logic        rvalid;
      logic [31:0] rdata;
      logic        error;
   } imem_rsp_type;

   // Force a fetch address onto a word boundary
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order entry queue with registered storage, synchronous flush and occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the producer must not push into a full queue without a pop.
module fetch_fifo #(
   parameter int  DEPTH = 4,
   parameter int  WIDTH = 65,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_pop;

   assign do_pop     = pop && (count != '0);
   assign head_valid = (count != '0);
   assign head_data  = mem[rd_ptr];

   // Storage write; no reset needed since count guards visibility
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy update; flush empties the queue in one cycle
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(do_pop);
      end
   end

   // Credit accounting upstream must make overflow impossible
   assert property (@(posedge clock) disable iff (reset || flush)
                    !(push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: issues word reads, queues in-order responses, presents {pc, instr} to decode.
// Latency: 1 cycle from imem_rvalid to fetch_valid; redirect takes effect the next cycle.
// Backpressure: fetch_ready low holds the head; requests stop when queue plus in-flight reach DEPTH.
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = reset_pc_default
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_valid,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        imem_error,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_instr,
   output logic        fetch_error,
   input  logic        fetch_ready
);

   localparam int          CW        = $clog2(DEPTH + 1);
   localparam int          OW        = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
   localparam logic [31:0] MAX_OUT_W = 32'(MAX_OUTSTANDING);

   logic [31:0]     req_pc;
   logic [31:0]     rsp_pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   discard;
   logic            halted;
   logic [CW-1:0]   count;
   logic            head_valid;
   fetch_entry_type head;
   fetch_entry_type push_entry;
   logic [31:0]     live_words;
   logic            accept;
   logic            push;

   // Words that will land in the queue: stored plus in-flight minus those to be dropped
   assign live_words = 32'(count) + 32'(outstanding) - 32'(discard);
   assign accept     = imem_valid && imem_ready;
   // Wrong-path responses are dropped while discarding or in a redirect cycle
   assign push       = imem_rvalid && !reset && !redirect && (discard == '0);

   assign push_entry.pc    = rsp_pc;
   assign push_entry.instr = imem_error ? nop_instr : imem_rdata;
   assign push_entry.error = imem_error;

   // Request generation and decode-side outputs, all forced low during reset
   always_comb begin
      imem_valid  = 1'b0;
      imem_addr   = '0;
      fetch_valid = 1'b0;
      fetch_pc    = '0;
      fetch_instr = '0;
      fetch_error = 1'b0;
      if (!reset) begin
         imem_valid  = !redirect && !halted &&
                       (32'(outstanding) < MAX_OUT_W) && (live_words < DEPTH_W);
         imem_addr   = req_pc;
         fetch_valid = head_valid;
         fetch_pc    = head.pc;
         fetch_instr = head.instr;
         fetch_error = head.error;
      end
   end

   // PC, credit, discard and halt bookkeeping; redirect overrides everything but the credit count
   always_ff @(posedge clock) begin
      if (reset) begin
         req_pc      <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         halted      <= 1'b0;
      end else begin
         outstanding <= outstanding + OW'(accept) - OW'(imem_rvalid);
         if (redirect) begin
            req_pc  <= word_align(redirect_pc);
            rsp_pc  <= word_align(redirect_pc);
            halted  <= 1'b0;
            discard <= outstanding - OW'(imem_rvalid);
         end else begin
            if (accept) begin
               req_pc <= req_pc + 32'd4;
            end
            if (imem_rvalid && (discard != '0)) begin
               discard <= discard - OW'(1);
            end
            if (push) begin
               rsp_pc <= rsp_pc + 32'd4;
               if (imem_error) begin
                  halted <= 1'b1;
               end
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_type))
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .flush      (redirect),
      .push       (push),
      .push_data  (push_entry),
      .pop        (fetch_ready && !redirect),
      .head_data  (head),
      .head_valid (head_valid),
      .count      (count)
   );

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

   localparam logic [31:0] RST_PC = 32'h0;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clock;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_valid;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        imem_error;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instr;
   logic        fetch_error;
   logic        fetch_ready;

   fetch_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RST_PC)) dut (
      .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_error(imem_error),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
      .fetch_error(fetch_error), .fetch_ready(fetch_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct { logic [31:0] addr; bit stale; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } ent_t;
   typedef struct { logic [31:0] rpc; int n_out; bit same_cycle; logic [31:0] exp_addr; } vec_t;

   req_t        mem_q[$];
   ent_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   bit          auto_resp;
   bit          err_en;
   logic [31:0] err_addr;
   logic [31:0] exp_req_pc;
   bit          tb_halted;
   int          accepts, pops, err_pops;
   bit          acc_seen;
   logic [31:0] first_acc_addr, first_pop_pc, err_pc, err_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs at the negedge, observe, then advance to the next negedge
   task automatic tick(input bit rd, input logic [31:0] rpc);
      req_t r;
      ent_t e;
      redirect    = rd;
      redirect_pc = rpc;
      imem_rvalid = auto_resp && !reset && (mem_q.size() > 0);
      imem_rdata  = imem_rvalid ? mem_word(mem_q[0].addr) : 32'h0;
      imem_error  = imem_rvalid && err_en && (mem_q[0].addr == err_addr);
      #1;
      if (reset) begin
         check("rst_imem_valid", imem_valid, 0);
         check("rst_imem_addr", imem_addr, 0);
         check("rst_fetch_valid", fetch_valid, 0);
         check("rst_fetch_pc", fetch_pc, 0);
         check("rst_fetch_instr", fetch_instr, 0);
         check("rst_fetch_error", fetch_error, 0);
         mem_q.delete();
         sb.delete();
         exp_req_pc = RST_PC;
         tb_halted  = 0;
      end else begin
         if (fetch_valid && fetch_ready && !rd) begin
            check("pop_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("pop_pc", fetch_pc, e.pc);
               check("pop_instr", fetch_instr, e.instr);
               check("pop_error", fetch_error, e.err);
            end
            if (pops == 0) first_pop_pc = fetch_pc;
            if (fetch_error) begin
               err_pops++;
               err_pc    = fetch_pc;
               err_instr = fetch_instr;
            end
            pops++;
         end
         if (imem_valid) begin
            check("req_in_redirect", rd, 0);
            check("req_while_halted", tb_halted, 0);
            if (imem_ready) begin
               check("req_addr", imem_addr, exp_req_pc);
               if (!acc_seen) first_acc_addr = imem_addr;
               acc_seen = 1;
               accepts++;
               mem_q.push_back('{addr: imem_addr, stale: 1'b0});
               exp_req_pc = exp_req_pc + 32'd4;
            end
         end
         if (imem_rvalid) begin
            r = mem_q.pop_front();
            if (!r.stale && !rd) begin
               sb.push_back('{pc: r.addr, instr: imem_error ? NOP : mem_word(r.addr), err: imem_error});
               if (imem_error) tb_halted = 1;
            end
         end
         if (rd) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            sb.delete();
            exp_req_pc = rpc & ~32'h3;
            tb_halted  = 0;
         end
      end
      @(posedge clock);
      @(negedge clock);
      redirect = 1'b0;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      tick(0, 0);
      tick(0, 0);
      reset    = 1'b0;
      accepts  = 0;
      pops     = 0;
      err_pops = 0;
      acc_seen = 0;
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{rpc: 32'h0000_0100, n_out: 2, same_cycle: 1'b0, exp_addr: 32'h0000_0100};
      vecs[1] = '{rpc: 32'h0000_0102, n_out: 2, same_cycle: 1'b1, exp_addr: 32'h0000_0100};
      vecs[2] = '{rpc: 32'h0000_0ABF, n_out: 1, same_cycle: 1'b1, exp_addr: 32'h0000_0ABC};
      vecs[3] = '{rpc: 32'hFFFF_FFFD, n_out: 1, same_cycle: 1'b0, exp_addr: 32'hFFFF_FFFC};
      vecs[4] = '{rpc: 32'h0000_0040, n_out: 0, same_cycle: 1'b0, exp_addr: 32'h0000_0040};

      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
      imem_rvalid = 1'b0; imem_rdata = '0; imem_error = 1'b0; fetch_ready = 1'b1;
      auto_resp = 1; err_en = 0; err_addr = '0; exp_req_pc = RST_PC; tb_halted = 0;
      accepts = 0; pops = 0; err_pops = 0; acc_seen = 0;
      first_acc_addr = '0; first_pop_pc = '0; err_pc = '0; err_instr = '0;
      @(negedge clock);

      // Streaming: one request per cycle, first decode 2 cycles after release
      reset_dut();
      #1;
      check("s_r0_fetch_valid", fetch_valid, 0);
      check("s_r0_imem_valid", imem_valid, 1);
      check("s_r0_imem_addr", imem_addr, RST_PC);
      tick(0, 0); #1;
      check("s_r1_fetch_valid", fetch_valid, 0);
      tick(0, 0); #1;
      check("s_r2_fetch_valid", fetch_valid, 1);
      check("s_r2_fetch_pc", fetch_pc, 32'h0);
      repeat (6) tick(0, 0);
      check("s_accepts", accepts, 8);
      check("s_pops", pops, 6);

      // Decoder stalled: credit stops at DEPTH, head stays put, then drains and resumes at 0x10
      fetch_ready = 1'b0;
      reset_dut();
      repeat (8) tick(0, 0);
      check("st_accepts", accepts, 4);
      #1;
      check("st_imem_valid", imem_valid, 0);
      check("st_head_valid", fetch_valid, 1);
      check("st_head_pc", fetch_pc, 32'h0);
      fetch_ready = 1'b1;
      repeat (6) tick(0, 0);
      check("st_pops_ge4", pops >= 4, 1);
      check("st_resumed", accepts >= 5, 1);

      // Redirect table: hold responses with n_out in flight, redirect, check restart
      foreach (vecs[v]) begin
         fetch_ready = 1'b1;
         reset_dut();
         auto_resp  = 0;
         imem_ready = 1'b1;
         tick(1, 32'h200);
         repeat (vecs[v].n_out) tick(0, 0);
         imem_ready = 1'b0;
         auto_resp  = vecs[v].same_cycle;
         tick(1, vecs[v].rpc);
         auto_resp  = 1;
         imem_ready = 1'b1;
         pops = 0;
         acc_seen = 0;
         repeat (8) tick(0, 0);
         check("rd_first_req", first_acc_addr, vecs[v].exp_addr);
         check("rd_first_pop", first_pop_pc, vecs[v].exp_addr);
         check("rd_popped", pops > 0, 1);
      end

      // Bus error at 0x40: nop + fault reaches decode, fetch halts until redirect
      fetch_ready = 1'b1;
      reset_dut();
      err_en = 1; err_addr = 32'h40;
      tick(1, 32'h38);
      repeat (10) tick(0, 0);
      check("err_pops", err_pops, 1);
      check("err_pc", err_pc, 32'h40);
      check("err_instr", err_instr, NOP);
      repeat (3) begin
         #1;
         check("err_halted_no_req", imem_valid, 0);
         tick(0, 0);
      end
      tick(1, 32'h80);
      #1;
      check("err_resume_valid", imem_valid, 1);
      check("err_resume_addr", imem_addr, 32'h80);
      repeat (4) tick(0, 0);
      err_en = 0;

      // Reset with a full queue and a redirect during reset: restart from RESET_PC
      fetch_ready = 1'b0;
      reset_dut();
      repeat (6) tick(0, 0);
      reset = 1'b1;
      tick(1, 32'h500);
      tick(0, 0);
      reset = 1'b0;
      pops = 0;
      #1;
      check("rr_fetch_valid", fetch_valid, 0);
      check("rr_imem_valid", imem_valid, 1);
      check("rr_imem_addr", imem_addr, RST_PC);
      fetch_ready = 1'b1;
      repeat (6) tick(0, 0);
      check("rr_first_pop", first_pop_pc, RST_PC);

      // Drain everything outstanding
      imem_ready = 1'b0;
      repeat (8) tick(0, 0);
      check("drain_sb_empty", sb.size(), 0);
      check("drain_mem_empty", mem_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
